sqrt_seq_param: RTL and testbench



---
 rtl/sqrt_pkg.sv | 24 ++
 rtl/sqrt_step.sv | 29 ++
 rtl/sqrt_seq_param.sv | 88 ++++++++
 tb/tb_sqrt_seq_param.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/sqrt_pkg.sv
// Shared definitions for the sequential integer square root: state encoding
// and elaboration-time helpers.
package sqrt_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        CALC = 1'b1
    } state_t;

    // One result bit is produced per iteration.
    function automatic int unsigned iter_count(input int unsigned width);
        return width / 2;
    endfunction

    function automatic int unsigned clog2(input int unsigned value);
        int unsigned r;
        r = 0;
        while ((64'd1 << r) < 64'(value)) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/sqrt_step.sv
// One digit-by-digit square root iteration: trial subtract of (y | m) from
// the partial remainder x, shifting the root accumulator right.
module sqrt_step
    import sqrt_pkg::*;
#(
    parameter int unsigned WIDTH = 16
) (
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  logic [WIDTH-1:0] m,
    output logic [WIDTH-1:0] x_next,
    output logic [WIDTH-1:0] y_next
);

    logic [WIDTH-1:0] b;

    // y and m never share set bits, so y | m equals y + m.
    always_comb begin
        b = y | m;
        if (x >= b) begin
            x_next = x - b;
            y_next = (y >> 1) | m;
        end else begin
            x_next = x;
            y_next = y >> 1;
        end
    end

endmodule

// File: rtl/sqrt_seq_param.sv
// Multi-cycle floor(sqrt(a)) with remainder, one result bit per clock, with a
// start/busy/done handshake. Latency is fixed at WIDTH/2 iterations.
module sqrt_seq_param
    import sqrt_pkg::*;
#(
    parameter int unsigned WIDTH = 16
) (
    input  logic                           clk_i,
    input  logic                           rst_i,
    input  logic                           start_i,
    input  logic [WIDTH-1:0]               a_bi,
    output logic                           busy_o,
    output logic                           done_o,
    output logic [iter_count(WIDTH)-1:0]   y_bo,
    output logic [iter_count(WIDTH):0]     rem_bo
);

    localparam int unsigned N    = iter_count(WIDTH);
    localparam int unsigned CntW = (clog2(N) > 0) ? clog2(N) : 1;
    localparam logic [WIDTH-1:0] MInit = WIDTH'(1) << (WIDTH - 2);

    if ((WIDTH < 4) || ((WIDTH % 2) != 0)) begin : g_bad_width
        $error("sqrt_seq_param: WIDTH must be even and >= 4");
    end

    state_t            state;
    logic [WIDTH-1:0]  x_q;
    logic [WIDTH-1:0]  y_q;
    logic [WIDTH-1:0]  m_q;
    logic [CntW-1:0]   cnt_q;
    logic [WIDTH-1:0]  x_next;
    logic [WIDTH-1:0]  y_next;

    sqrt_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .x      (x_q),
        .y      (y_q),
        .m      (m_q),
        .x_next (x_next),
        .y_next (y_next)
    );

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state  <= IDLE;
            x_q    <= '0;
            y_q    <= '0;
            m_q    <= '0;
            cnt_q  <= '0;
            busy_o <= 1'b0;
            done_o <= 1'b0;
            y_bo   <= '0;
            rem_bo <= '0;
        end else begin
            done_o <= 1'b0;
            case (state)
                IDLE: begin
                    if (start_i) begin
                        x_q    <= a_bi;
                        y_q    <= '0;
                        m_q    <= MInit;
                        cnt_q  <= CntW'(N - 1);
                        busy_o <= 1'b1;
                        state  <= CALC;
                    end
                end
                CALC: begin
                    x_q <= x_next;
                    y_q <= y_next;
                    m_q <= m_q >> 2;
                    if (cnt_q == '0) begin
                        // After the last step the root and remainder fit N and N+1 bits.
                        y_bo   <= y_next[N-1:0];
                        rem_bo <= x_next[N:0];
                        done_o <= 1'b1;
                        busy_o <= 1'b0;
                        state  <= IDLE;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sqrt_seq_param.sv
// Self-checking bench for sqrt_seq_param at WIDTH 8, 16 and 32: directed
// table, handshake corner cases, and random operands against an isqrt model.
module tb_sqrt_seq_param;

    logic clk = 1'b0;
    logic rst = 1'b0;

    logic        start8 = 1'b0, start16 = 1'b0, start32 = 1'b0;
    logic [7:0]  a8  = '0;
    logic [15:0] a16 = '0;
    logic [31:0] a32 = '0;
    logic        busy8, busy16, busy32, done8, done16, done32;
    logic [3:0]  y8;
    logic [4:0]  rem8;
    logic [7:0]  y16;
    logic [8:0]  rem16;
    logic [15:0] y32;
    logic [16:0] rem32;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    sqrt_seq_param #(.WIDTH(8)) u8 (
        .clk_i(clk), .rst_i(rst), .start_i(start8), .a_bi(a8),
        .busy_o(busy8), .done_o(done8), .y_bo(y8), .rem_bo(rem8)
    );
    sqrt_seq_param #(.WIDTH(16)) u16 (
        .clk_i(clk), .rst_i(rst), .start_i(start16), .a_bi(a16),
        .busy_o(busy16), .done_o(done16), .y_bo(y16), .rem_bo(rem16)
    );
    sqrt_seq_param #(.WIDTH(32)) u32 (
        .clk_i(clk), .rst_i(rst), .start_i(start32), .a_bi(a32),
        .busy_o(busy32), .done_o(done32), .y_bo(y32), .rem_bo(rem32)
    );

    typedef struct {
        int          w;
        logic [31:0] a;
        logic [31:0] y;
        logic [31:0] rem;
    } vec_t;

    task automatic check(input string name, input longint act, input longint exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Reference: largest r with r*r <= a, found by binary search.
    function automatic longint isqrt(input longint a);
        longint lo = 0;
        longint hi = 65536;
        longint mid;
        while (hi - lo > 1) begin
            mid = (lo + hi) / 2;
            if (mid * mid <= a) lo = mid;
            else hi = mid;
        end
        return lo;
    endfunction

    task automatic drive(input int w, input logic s, input logic [31:0] a);
        case (w)
            8:       begin start8  = s; a8  = a[7:0];  end
            16:      begin start16 = s; a16 = a[15:0]; end
            default: begin start32 = s; a32 = a;       end
        endcase
    endtask

    function automatic logic get_done(input int w);
        return (w == 8) ? done8 : (w == 16) ? done16 : done32;
    endfunction

    function automatic logic get_busy(input int w);
        return (w == 8) ? busy8 : (w == 16) ? busy16 : busy32;
    endfunction

    function automatic logic [31:0] get_y(input int w);
        return (w == 8) ? 32'(y8) : (w == 16) ? 32'(y16) : 32'(y32);
    endfunction

    function automatic logic [31:0] get_rem(input int w);
        return (w == 8) ? 32'(rem8) : (w == 16) ? 32'(rem16) : 32'(rem32);
    endfunction

    // Called just after the accepting edge; lat = edges until done seen, -1 on timeout.
    task automatic wait_done(input int w, output int lat, output int busy_cycles);
        lat = -1;
        busy_cycles = 0;
        for (int k = 1; k <= 40; k++) begin
            if (get_busy(w)) busy_cycles++;
            @(posedge clk); #1;
            if (get_done(w)) begin
                lat = k;
                break;
            end
        end
    endtask

    task automatic run_op(input int w, input logic [31:0] a, output logic [31:0] y,
                          output logic [31:0] rem, output int lat, output int busy_cycles);
        drive(w, 1'b1, a);
        @(posedge clk); #1;
        drive(w, 1'b0, '0);
        wait_done(w, lat, busy_cycles);
        y = get_y(w);
        rem = get_rem(w);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t        vt[10];
        logic [31:0] y, rem, a;
        int          lat, bc, dn;
        longint      ey;

        vt[0] = '{16, 26, 5, 1};
        vt[1] = '{16, 0, 0, 0};
        vt[2] = '{16, 1, 1, 0};
        vt[3] = '{16, 2, 1, 1};
        vt[4] = '{16, 9, 3, 0};
        vt[5] = '{16, 16, 4, 0};
        vt[6] = '{16, 25, 5, 0};
        vt[7] = '{16, 65535, 255, 510};
        vt[8] = '{8, 255, 15, 30};
        vt[9] = '{32, 32'hFFFF_FFFF, 65535, 131070};

        #2 rst = 1'b1;
        #1;
        check("reset_busy", busy16, 0);
        check("reset_done", done16, 0);
        check("reset_y", y16, 0);
        check("reset_rem", rem16, 0);
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;

        // Directed table; done is seen #1 after edge N, i.e. sampled at edge N+1.
        foreach (vt[i]) begin
            run_op(vt[i].w, vt[i].a, y, rem, lat, bc);
            check($sformatf("tbl%0d_y", i), y, vt[i].y);
            check($sformatf("tbl%0d_rem", i), rem, vt[i].rem);
            check($sformatf("tbl%0d_lat", i), lat, vt[i].w / 2);
            check($sformatf("tbl%0d_busy", i), bc, vt[i].w / 2);
            @(posedge clk); #1;
            check($sformatf("tbl%0d_pulse", i), get_done(vt[i].w), 0);
        end

        // start while busy is ignored; outputs hold across a new start
        run_op(16, 26, y, rem, lat, bc);
        drive(16, 1'b1, 100);
        @(posedge clk); #1;
        drive(16, 1'b0, '0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("hold_y", y16, 5);
        check("hold_rem", rem16, 1);
        drive(16, 1'b1, 4);
        @(posedge clk); #1;
        drive(16, 1'b0, '0);
        wait_done(16, lat, bc);
        check("ign_lat", lat, 5);
        check("ign_y", y16, 10);
        check("ign_rem", rem16, 0);
        dn = 0;
        for (int k = 0; k < 12; k++) begin
            @(posedge clk); #1;
            if (done16) dn++;
        end
        check("ign_no_queue", dn, 0);

        // asynchronous reset mid-operation
        drive(16, 1'b1, 1000);
        @(posedge clk); #1;
        drive(16, 1'b0, '0);
        @(posedge clk); @(posedge clk); #3;
        rst = 1'b1;
        #1;
        check("arst_busy", busy16, 0);
        check("arst_done", done16, 0);
        check("arst_y", y16, 0);
        check("arst_rem", rem16, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        dn = 0;
        for (int k = 0; k < 12; k++) begin
            @(posedge clk); #1;
            if (done16) dn++;
        end
        check("arst_no_done", dn, 0);
        run_op(16, 49, y, rem, lat, bc);
        check("arst_after_y", y, 7);
        check("arst_after_rem", rem, 0);

        // start held high across done: back-to-back acceptance in the done cycle
        drive(16, 1'b1, 81);
        @(posedge clk); #1;
        wait_done(16, lat, bc);
        check("b2b1_lat", lat, 8);
        check("b2b1_y", y16, 9);
        check("b2b1_rem", rem16, 0);
        drive(16, 1'b1, 80);
        @(posedge clk); #1;
        drive(16, 1'b0, '0);
        check("b2b_accept", busy16, 1);
        wait_done(16, lat, bc);
        check("b2b2_lat", lat + 1, 9);
        check("b2b2_y", y16, 8);
        check("b2b2_rem", rem16, 16);

        // random operands against the model
        for (int i = 0; i < 150; i++) begin
            int w;
            w = (i % 3 == 0) ? 8 : (i % 3 == 1) ? 16 : 32;
            a = $urandom;
            if (w == 8) a = a & 32'hFF;
            else if (w == 16) a = a & 32'hFFFF;
            run_op(w, a, y, rem, lat, bc);
            ey = isqrt(longint'(a));
            check($sformatf("rnd%0d_w%0d_a%0d_y", i, w, a), y, ey);
            check($sformatf("rnd%0d_w%0d_a%0d_rem", i, w, a), rem, longint'(a) - ey * ey);
            check($sformatf("rnd%0d_lat", i), lat, w / 2);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
